// File: rtl/sd_cmd_arbiter.sv
// Shares one SD command master between the host register path and the data master.
// Define SD_CMD_ARB_HOST_PRIORITY_EN for fixed host priority instead of round-robin.
module sd_cmd_arbiter #(
    parameter int unsigned TO_PRESCALE = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        host_req_i,
    input  logic [15:0] host_cmd_set_i,
    input  logic [31:0] host_cmd_arg_i,
    input  logic        dm_req_i,
    input  logic [15:0] dm_cmd_set_i,
    input  logic [31:0] dm_cmd_arg_i,
    output logic        dm_ack_o,
    output logic        cmd_start_o,
    output logic [15:0] cmd_set_o,
    output logic [31:0] cmd_arg_o,
    input  logic        cmd_busy_i,
    input  logic        cmd_done_i,
    input  logic        cmd_err_i,
    input  logic [15:0] time_out_i,
    output logic        owner_o,
    output logic        host_busy_o,
    output logic        dm_busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        timeout_o
);

    localparam int unsigned PW = (TO_PRESCALE > 1) ? $clog2(TO_PRESCALE) : 1;
    localparam logic [PW-1:0] PrescLast = PW'(TO_PRESCALE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone,
        StRelease
    } state_e;

    state_e        state_q, state_d;
    logic          host_pend_q, host_pend_d;
    logic [15:0]   host_set_q, host_set_d;
    logic [31:0]   host_arg_q, host_arg_d;
    logic          owner_q, owner_d;
    logic          last_owner_q, last_owner_d;
    logic [15:0]   cmd_set_q, cmd_set_d;
    logic [31:0]   cmd_arg_q, cmd_arg_d;
    logic          err_seen_q, err_seen_d;
    logic          to_seen_q, to_seen_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   tick_q, tick_d;

    logic          grant_host;
    logic          grant_dm;
    logic          presc_wrap;
    logic [15:0]   tick_nxt;
    logic          expire;

    // Requester selection; only acted upon while idle.
    always_comb begin
        grant_host = 1'b0;
        grant_dm   = 1'b0;
        if (host_pend_q && dm_req_i) begin
`ifdef SD_CMD_ARB_HOST_PRIORITY_EN
            grant_host = 1'b1;
`else
            grant_host = last_owner_q;
            grant_dm   = ~last_owner_q;
`endif
        end else begin
            grant_host = host_pend_q;
            grant_dm   = dm_req_i;
        end
    end

    // Tick counter saturates so a disabled timeout can never wrap into a false expiry.
    always_comb begin
        presc_wrap = (presc_q == PrescLast);
        tick_nxt   = tick_q;
        if (presc_wrap && (tick_q != 16'hFFFF)) begin
            tick_nxt = tick_q + 16'd1;
        end
        expire = (time_out_i != 16'd0) && (tick_nxt >= time_out_i);
    end

    always_comb begin
        state_d      = state_q;
        host_set_d   = host_set_q;
        host_arg_d   = host_arg_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cmd_set_d    = cmd_set_q;
        cmd_arg_d    = cmd_arg_q;
        err_seen_d   = err_seen_q;
        to_seen_d    = to_seen_q;
        presc_d      = presc_q;
        tick_d       = tick_q;

        if (host_req_i) begin
            host_set_d = host_cmd_set_i;
            host_arg_d = host_cmd_arg_i;
        end

        unique case (state_q)
            StIdle: begin
                if (grant_host || grant_dm) begin
                    owner_d   = grant_dm;
                    cmd_set_d = grant_dm ? dm_cmd_set_i : host_set_q;
                    cmd_arg_d = grant_dm ? dm_cmd_arg_i : host_arg_q;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                presc_d = '0;
                tick_d  = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                presc_d = presc_wrap ? '0 : presc_q + 1'b1;
                tick_d  = tick_nxt;
                if (expire) begin
                    to_seen_d = 1'b1;
                    state_d   = StRelease;
                end else if (cmd_done_i) begin
                    state_d = StRelease;
                end else if (cmd_busy_i) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                presc_d = presc_wrap ? '0 : presc_q + 1'b1;
                tick_d  = tick_nxt;
                if (expire) begin
                    to_seen_d = 1'b1;
                end
                if (cmd_err_i) begin
                    err_seen_d = 1'b1;
                end
                if (expire || cmd_done_i || cmd_err_i) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                last_owner_d = owner_q;
                err_seen_d   = 1'b0;
                to_seen_d    = 1'b0;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A new host write re-arms the pending flag even in the cycle it is granted.
        host_pend_d = host_req_i | (host_pend_q & ~((state_q == StIdle) & grant_host));
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= StIdle;
            host_pend_q  <= 1'b0;
            host_set_q   <= '0;
            host_arg_q   <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            cmd_set_q    <= '0;
            cmd_arg_q    <= '0;
            err_seen_q   <= 1'b0;
            to_seen_q    <= 1'b0;
            presc_q      <= '0;
            tick_q       <= '0;
        end else begin
            state_q      <= state_d;
            host_pend_q  <= host_pend_d;
            host_set_q   <= host_set_d;
            host_arg_q   <= host_arg_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cmd_set_q    <= cmd_set_d;
            cmd_arg_q    <= cmd_arg_d;
            err_seen_q   <= err_seen_d;
            to_seen_q    <= to_seen_d;
            presc_q      <= presc_d;
            tick_q       <= tick_d;
        end
    end

    // Pulses are suppressed while reset is asserted so an abort emits nothing.
    always_comb begin
        dm_ack_o    = (state_q == StIdle) && grant_dm && !wb_rst_i;
        cmd_start_o = (state_q == StIssue) && !wb_rst_i;
        done_o      = (state_q == StRelease) && !wb_rst_i;
        err_o       = done_o && err_seen_q;
        timeout_o   = done_o && to_seen_q;
        host_busy_o = host_pend_q || ((state_q != StIdle) && !owner_q);
        dm_busy_o   = (state_q != StIdle) && owner_q;
        owner_o     = owner_q;
        cmd_set_o   = cmd_set_q;
        cmd_arg_o   = cmd_arg_q;
    end

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Scoreboard bench for sd_cmd_arbiter: expected commands/statuses are queued by the
// stimulus and a negedge monitor pops them whenever the DUT starts or releases a command.
module tb_sd_cmd_arbiter;

    localparam int unsigned TO_PRESCALE = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        host_req_i = 1'b0;
    logic [15:0] host_cmd_set_i = '0;
    logic [31:0] host_cmd_arg_i = '0;
    logic        dm_req_i = 1'b0;
    logic [15:0] dm_cmd_set_i = '0;
    logic [31:0] dm_cmd_arg_i = '0;
    logic        dm_ack_o;
    logic        cmd_start_o;
    logic [15:0] cmd_set_o;
    logic [31:0] cmd_arg_o;
    logic        cmd_busy_i = 1'b0;
    logic        cmd_done_i = 1'b0;
    logic        cmd_err_i = 1'b0;
    logic [15:0] time_out_i = '0;
    logic        owner_o;
    logic        host_busy_o;
    logic        dm_busy_o;
    logic        done_o;
    logic        err_o;
    logic        timeout_o;

    always #5 clk = ~clk;

    sd_cmd_arbiter #(.TO_PRESCALE(TO_PRESCALE)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .host_req_i    (host_req_i),
        .host_cmd_set_i(host_cmd_set_i),
        .host_cmd_arg_i(host_cmd_arg_i),
        .dm_req_i      (dm_req_i),
        .dm_cmd_set_i  (dm_cmd_set_i),
        .dm_cmd_arg_i  (dm_cmd_arg_i),
        .dm_ack_o      (dm_ack_o),
        .cmd_start_o   (cmd_start_o),
        .cmd_set_o     (cmd_set_o),
        .cmd_arg_o     (cmd_arg_o),
        .cmd_busy_i    (cmd_busy_i),
        .cmd_done_i    (cmd_done_i),
        .cmd_err_i     (cmd_err_i),
        .time_out_i    (time_out_i),
        .owner_o       (owner_o),
        .host_busy_o   (host_busy_o),
        .dm_busy_o     (dm_busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .timeout_o     (timeout_o)
    );

    typedef struct packed {
        logic [15:0] cset;
        logic [31:0] carg;
        logic        owner;
    } cmd_t;

    cmd_t       exp_cmd[$];
    logic [1:0] exp_st[$];   // {err, timeout}
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_cyc = 0;
    int issue_cyc = 0;
    int rel_cyc = 0;
    int ack_cyc = 0;
    int mon_acks = 0;
    int exp_acks = 0;
    bit last_start = 1'b0;
    bit last_done = 1'b0;
    bit last_ack = 1'b0;
    bit model_last_owner = 1'b1;

    function automatic cmd_t mk(input logic [15:0] s, input logic [31:0] a, input logic o);
        cmd_t c;
        c.cset  = s;
        c.carg  = a;
        c.owner = o;
        return c;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every start and release against the queued expectations.
    always @(negedge clk) begin
        if (cmd_start_o) begin
            if (exp_cmd.size() == 0) begin
                check("unexpected_start", 64'(1), 64'(0));
            end else begin
                cmd_t e;
                e = exp_cmd.pop_front();
                check("cmd_set", 64'(cmd_set_o), 64'(e.cset));
                check("cmd_arg", 64'(cmd_arg_o), 64'(e.carg));
                check("owner", 64'(owner_o), 64'(e.owner));
            end
        end
        if (done_o) begin
            if (exp_st.size() == 0) begin
                check("unexpected_done", 64'(1), 64'(0));
            end else begin
                logic [1:0] s;
                s = exp_st.pop_front();
                check("release_status", 64'({err_o, timeout_o}), 64'(s));
            end
        end
        if (dm_ack_o) mon_acks++;
    end

    // One clock: sample at negedge, drive just after the next posedge.
    task automatic step();
        @(negedge clk);
        last_start = cmd_start_o;
        last_done  = done_o;
        last_ack   = dm_ack_o;
        last_cyc   = cyc;
        if (last_ack) ack_cyc = cyc;
        @(posedge clk);
        #1;
        if (last_ack) dm_req_i = 1'b0;
    endtask

    task automatic pulse_host(input logic [15:0] s, input logic [31:0] a);
        host_req_i     = 1'b1;
        host_cmd_set_i = s;
        host_cmd_arg_i = a;
        step();
        host_req_i = 1'b0;
    endtask

    task automatic dm_raise(input logic [15:0] s, input logic [31:0] a);
        dm_req_i     = 1'b1;
        dm_cmd_set_i = s;
        dm_cmd_arg_i = a;
        exp_acks++;
    endtask

    task automatic wait_start();
        int n = 0;
        do begin
            step();
            n++;
        end while (!last_start && n < 50);
        check("start_seen", 64'(last_start), 64'(1));
        issue_cyc = last_cyc;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            step();
            n++;
        end while (!last_done && n < 2000);
        check("done_seen", 64'(last_done), 64'(1));
        rel_cyc = last_cyc;
    endtask

    // Plays the command master for one command.
    // mode 0 busy+done, 1 done w/o busy, 2 err+done, 3 err only, 4 timeout.
    task automatic serve(input bit owner, input bit pend, input int mode, input bit ovr);
        int dp;
        int t;
        wait_start();
        check("dm_busy", 64'(dm_busy_o), 64'(owner));
        check("host_busy", 64'(host_busy_o), 64'((!owner) | pend));
        model_last_owner = owner;
        time_out_i = ($urandom_range(0, 1) != 0) ? 16'd200 : 16'd0;
        if (ovr) begin
            cmd_t h;
            h = mk(16'($urandom), 32'h0000_000B, 1'b0);
            pulse_host(16'($urandom), 32'h0000_000A);
            pulse_host(h.cset, h.carg);
            exp_cmd.push_back(h);
            check("host_busy_pending", 64'(host_busy_o), 64'(1));
        end
        case (mode)
            0, 2, 3: begin
                exp_st.push_back((mode == 0) ? 2'b00 : 2'b10);
                cmd_busy_i = 1'b1;
                repeat ($urandom_range(1, 3)) step();
                cmd_done_i = (mode != 3);
                cmd_err_i  = (mode != 0);
                dp = cyc;
                step();
                cmd_done_i = 1'b0;
                cmd_err_i  = 1'b0;
                cmd_busy_i = 1'b0;
                wait_done();
                check("release_latency", 64'(rel_cyc - dp), 64'(1));
            end
            1: begin
                exp_st.push_back(2'b00);
                repeat ($urandom_range(0, 2)) step();
                cmd_done_i = 1'b1;
                dp = cyc;
                step();
                cmd_done_i = 1'b0;
                wait_done();
                check("release_latency_nobusy", 64'(rel_cyc - dp), 64'(1));
            end
            default: begin
                t = $urandom_range(1, 3);
                exp_st.push_back(2'b01);
                cmd_busy_i = 1'b1;
                time_out_i = 16'(t);
                wait_done();
                cmd_busy_i = 1'b0;
                check("timeout_latency", 64'(rel_cyc - issue_cyc), 64'(TO_PRESCALE * t + 1));
            end
        endcase
        time_out_i = 16'd0;
    endtask

    task automatic contend(input int m1, input int m2);
        cmd_t h;
        cmd_t d;
        bit host_first;
        int r;
        h = mk(16'($urandom), 32'($urandom), 1'b0);
        d = mk(16'($urandom), 32'($urandom), 1'b1);
`ifdef SD_CMD_ARB_HOST_PRIORITY_EN
        host_first = 1'b1;
`else
        host_first = model_last_owner;
`endif
        pulse_host(h.cset, h.carg);
        dm_raise(d.cset, d.carg);
        if (host_first) begin
            exp_cmd.push_back(h);
            exp_cmd.push_back(d);
            serve(1'b0, 1'b0, m1, 1'b0);
            r = rel_cyc;
            serve(1'b1, 1'b0, m2, 1'b0);
            check("dm_ack_after_release", 64'(ack_cyc - r), 64'(1));
        end else begin
            exp_cmd.push_back(d);
            exp_cmd.push_back(h);
            serve(1'b1, 1'b1, m1, 1'b0);
            serve(1'b0, 1'b0, m2, 1'b0);
        end
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check("reset_outputs", 64'({dm_ack_o, cmd_start_o, cmd_set_o, cmd_arg_o, owner_o,
                                    host_busy_o, dm_busy_o, done_o, err_o, timeout_o}), 64'(0));

        // Host only, fixed values, start two cycles after the request.
        exp_cmd.push_back(mk(16'h0502, 32'h1234_5678, 1'b0));
        k = cyc;
        pulse_host(16'h0502, 32'h1234_5678);
        serve(1'b0, 1'b0, 0, 1'b0);
        check("host_issue_latency", 64'(issue_cyc - k), 64'(2));

        // Contention twice, then timeout, error followed by a clean command.
        contend(0, 1);
        contend(1, 0);
        exp_cmd.push_back(mk(16'h0011, 32'h0000_0003, 1'b0));
        pulse_host(16'h0011, 32'h0000_0003);
        serve(1'b0, 1'b0, 4, 1'b0);
        exp_cmd.push_back(mk(16'h0022, 32'h0000_0044, 1'b0));
        pulse_host(16'h0022, 32'h0000_0044);
        serve(1'b0, 1'b0, 2, 1'b0);
        exp_cmd.push_back(mk(16'h0033, 32'h0000_0055, 1'b0));
        pulse_host(16'h0033, 32'h0000_0055);
        serve(1'b0, 1'b0, 0, 1'b0);

        // Host overwrite while a data-master command is in flight.
        exp_cmd.push_back(mk(16'h1111, 32'hCAFE_0001, 1'b1));
        dm_raise(16'h1111, 32'hCAFE_0001);
        serve(1'b1, 1'b0, 0, 1'b1);
        serve(1'b0, 1'b0, 1, 1'b0);

        // Disabled timeout waits forever; reset aborts mid-command.
        exp_cmd.push_back(mk(16'h0777, 32'h0000_0777, 1'b0));
        pulse_host(16'h0777, 32'h0000_0777);
        wait_start();
        cmd_busy_i = 1'b1;
        time_out_i = 16'd0;
        repeat (60) step();
        check("still_waiting", 64'(host_busy_o), 64'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        cmd_busy_i = 1'b0;
        #1;
        check("abort_outputs", 64'({dm_ack_o, cmd_start_o, cmd_set_o, cmd_arg_o, owner_o,
                                    host_busy_o, dm_busy_o, done_o, err_o, timeout_o}), 64'(0));
        model_last_owner = 1'b1;
        step();

        // Randomized rounds.
        for (int i = 0; i < 40; i++) begin
            int kind;
            int m;
            cmd_t c;
            kind = $urandom_range(0, 3);
            m = $urandom_range(0, 4);
            case (kind)
                0: begin
                    c = mk(16'($urandom), 32'($urandom), 1'b0);
                    exp_cmd.push_back(c);
                    pulse_host(c.cset, c.carg);
                    serve(1'b0, 1'b0, m, 1'b0);
                end
                1: begin
                    c = mk(16'($urandom), 32'($urandom), 1'b1);
                    exp_cmd.push_back(c);
                    dm_raise(c.cset, c.carg);
                    serve(1'b1, 1'b0, m, 1'b0);
                end
                2: contend(m, $urandom_range(0, 4));
                default: begin
                    c = mk(16'($urandom), 32'($urandom), 1'b1);
                    exp_cmd.push_back(c);
                    dm_raise(c.cset, c.carg);
                    serve(1'b1, 1'b0, m, 1'b1);
                    serve(1'b0, 1'b0, $urandom_range(0, 4), 1'b0);
                end
            endcase
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (4) step();
        check("cmd_queue_drained", 64'(exp_cmd.size()), 64'(0));
        check("status_queue_drained", 64'(exp_st.size()), 64'(0));
        check("dm_ack_count", 64'(mon_acks), 64'(exp_acks));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_cmd_arbiter.md
Name: sd_cmd_arbiter

Overview:
- Shares the single SD command master between two requesters: the host (Wishbone register writes) and the internal data master (automatic CMD17/CMD24-style requests).
- Latches each request, grants one at a time, and drives a one-cycle start pulse with the command setting and argument.
- Tracks completion, error and timeout, then releases the command master and reports status back to the owning requester.

Parameters:
- TO_PRESCALE, 8, number of clock cycles per timeout tick; time_out value is counted in ticks.

Ports:
- wb_clk_i  in  1  system clock; all logic is on the rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- host_req_i  in  1  one-cycle pulse: host wrote a new command.
- host_cmd_set_i  in  16  host command setting.
- host_cmd_arg_i  in  32  host command argument.
- dm_req_i  in  1  data-master request; level, held until dm_ack_o.
- dm_cmd_set_i  in  16  data-master command setting.
- dm_cmd_arg_i  in  32  data-master command argument.
- dm_ack_o  out  1  one-cycle pulse: data-master request accepted.
- cmd_start_o  out  1  one-cycle pulse to the command master.
- cmd_set_o  out  16  command setting presented with cmd_start_o.
- cmd_arg_o  out  32  command argument presented with cmd_start_o.
- cmd_busy_i  in  1  command master busy (status bit 0).
- cmd_done_i  in  1  one-cycle pulse: command/response complete.
- cmd_err_i  in  1  one-cycle pulse: CRC/index/end-bit error.
- time_out_i  in  16  timeout in ticks; 0 disables the timeout.
- owner_o  out  1  current or last owner: 0 = host, 1 = data master.
- host_busy_o  out  1  host command pending or in flight.
- dm_busy_o  out  1  data-master command in flight.
- done_o  out  1  one-cycle pulse at release.
- err_o  out  1  one-cycle pulse at release when an error was seen.
- timeout_o  out  1  one-cycle pulse at release when the timeout expired.

Behaviour:
- Reset (synchronous): state IDLE, host_pend=0, last_owner=1. All outputs are 0, including cmd_set_o and cmd_arg_o.
- Host pending latch:
  - host_req_i sets host_pend and captures host_cmd_set_i/host_cmd_arg_i into a shadow register.
  - A second host_req_i while pending overwrites the shadow (last write wins).
  - A host_req_i while the host command is in flight sets host_pend for the next round and does not disturb the current command.
- host_busy_o = host_pend | (state != IDLE & owner = host).
- dm_busy_o = (state != IDLE & owner = dm).
- IDLE:
  - If exactly one of host_pend / dm_req_i is set, grant that requester.
  - If both are set, round-robin: grant the requester that is not last_owner.
  - On grant: load cmd_set_o/cmd_arg_o, set owner_o, go to ISSUE. A host grant clears host_pend; a dm grant pulses dm_ack_o in the same cycle.
- ISSUE: cmd_start_o=1 for exactly one cycle. Clear the timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY:
  - On cmd_busy_i=1, go to WAIT_DONE.
  - If cmd_done_i arrives first, go to RELEASE (covers commands with no response).
  - Timeout counting applies here as well.
- WAIT_DONE:
  - cmd_done_i goes to RELEASE.
  - cmd_err_i latches err_seen and goes to RELEASE.
  - If done and err arrive in the same cycle, both are recorded.
- Timeout counter:
  - Prescaler counts 0..TO_PRESCALE-1; the tick counter increments on wrap.
  - When tick count = time_out_i (nonzero), latch to_seen and go to RELEASE.
  - time_out_i is sampled live. Lowering it below the current count causes an immediate expiry at the next compare.
- RELEASE (one cycle):
  - done_o=1; err_o=err_seen; timeout_o=to_seen.
  - last_owner <= owner; clear err_seen and to_seen; go to IDLE.
  - The next grant can occur in the following cycle (minimum spacing between cmd_start_o pulses is 4 cycles).
- cmd_set_o/cmd_arg_o hold their value from the grant until the next grant.
- Reset mid-operation aborts immediately to the reset state. No pulses are emitted that cycle.

Optional Feature:
- Macro: SD_CMD_ARB_HOST_PRIORITY_EN.
- Defined: fixed priority; the host always wins when both requesters are pending. last_owner is still updated but ignored.
- Undefined: round-robin as described above.

Test Plan:
- Host only: host_req_i with set=0x0502, arg=0x12345678 at cycle 0.
  - Required: cmd_start_o at cycle 2 with those values, owner_o=0.
  - Then cmd_busy_i=1 followed by cmd_done_i gives done_o 1 cycle later, err_o=0.
- Contention: host_pend and dm_req_i set together after reset (last_owner=1).
  - Required: host granted first; dm_ack_o pulses in the IDLE cycle after the host's RELEASE.
  - Repeating the contention gives dm first (round-robin).
  - With SD_CMD_ARB_HOST_PRIORITY_EN defined, the host wins both times.
- Timeout: time_out_i=3, TO_PRESCALE=8, no cmd_done_i.
  - Required: timeout_o and done_o pulse 24 cycles after leaving ISSUE.
  - With time_out_i=0, the arbiter stays in WAIT_DONE indefinitely.
- Error: cmd_err_i and cmd_done_i in the same cycle in WAIT_DONE.
  - Required: next cycle done_o=1 and err_o=1; the following grant shows err_o=0.
- Host overwrite: two host_req_i pulses while a dm command is in flight (arg 0xA, then 0xB).
  - Required: after dm release, a single host command issues with cmd_arg_o=0xB.
- Reset mid-command: assert wb_rst_i in WAIT_DONE.
  - Required: next cycle all outputs are 0 and host_busy_o=0; no done_o.
